// File: rtl/logic_pipe.sv
// Bitwise logic unit behind an elastic valid/ready pipeline.
// Results flow through STAGES registers with bubble collapse.
module logic_pipe #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_zero,
  output logic [31:0]      acc_count
);

  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $error("logic_pipe: WIDTH must be 1..64");
  end
  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("logic_pipe: STAGES must be 1..4");
  end

  logic [STAGES-1:0] vld_q, vld_d;
  logic [STAGES-1:0] zro_q, zro_d;
  logic [STAGES-1:0] load;
  logic [WIDTH-1:0]  dat_q [STAGES];
  logic [WIDTH-1:0]  dat_d [STAGES];
  logic [WIDTH-1:0]  res;
  logic [31:0]       acc_q, acc_d;
  logic              chain;
  logic              accept;

  always_comb begin
    res = '0;
    unique case (op)
      3'd0: res = ~in1;
      3'd1: res = in1 & in2;
      3'd2: res = ~(in1 & in2);
      3'd3: res = in1 | in2;
      3'd4: res = ~(in1 | in2);
      3'd5: res = in1 ^ in2;
      3'd6: res = in3[0] ? in2 : in1;
      3'd7: res = (in1 & in2) | (in1 & in3) | (in2 & in3);
    endcase
  end

  // A stage can load when it is empty or its content moves on.
  always_comb begin
    load  = '0;
    chain = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      chain   = !vld_q[k] || chain;
      load[k] = chain;
    end
  end

  assign in_ready = !rst && load[0];
  assign accept   = in_valid && in_ready;

  always_comb begin
    vld_d = vld_q;
    zro_d = zro_q;
    for (int k = 0; k < STAGES; k++) begin
      dat_d[k] = dat_q[k];
    end
    if (load[0]) begin
      vld_d[0] = accept;
      if (accept) begin
        dat_d[0] = res;
        zro_d[0] = (res == '0);
      end
    end
    for (int k = 1; k < STAGES; k++) begin
      if (load[k]) begin
        vld_d[k] = vld_q[k-1];
        if (vld_q[k-1]) begin
          dat_d[k] = dat_q[k-1];
          zro_d[k] = zro_q[k-1];
        end
      end
    end
    acc_d = accept ? acc_q + 32'd1 : acc_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      zro_q <= '1;
      acc_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        dat_q[k] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      zro_q <= zro_d;
      acc_q <= acc_d;
      for (int k = 0; k < STAGES; k++) begin
        dat_q[k] <= dat_d[k];
      end
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign out       = dat_q[STAGES-1];
  assign out_zero  = zro_q[STAGES-1];
  assign acc_count = acc_q;

endmodule

// File: tb/tb_logic_pipe.sv
// Directed bench for logic_pipe at STAGES 1, 2 and 4.
// Inputs are shared; backpressure/reset checks use the 2-stage unit.
module tb_logic_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [2:0]  op;
  logic [63:0] in1, in2, in3;

  logic        rdy1, rdy2, rdy4;
  logic        ov1, ov2, ov4;
  logic [63:0] od1, od2, od4;
  logic        oz1, oz2, oz4;
  logic [31:0] ac1, ac2, ac4;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  logic_pipe #(.WIDTH(64), .STAGES(2)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2),
    .op(op), .in1(in1), .in2(in2), .in3(in3),
    .out_valid(ov2), .out_ready(out_ready), .out(od2),
    .out_zero(oz2), .acc_count(ac2)
  );

  logic_pipe #(.WIDTH(64), .STAGES(1)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
    .op(op), .in1(in1), .in2(in2), .in3(in3),
    .out_valid(ov1), .out_ready(out_ready), .out(od1),
    .out_zero(oz1), .acc_count(ac1)
  );

  logic_pipe #(.WIDTH(64), .STAGES(4)) u_s4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4),
    .op(op), .in1(in1), .in2(in2), .in3(in3),
    .out_valid(ov4), .out_ready(out_ready), .out(od4),
    .out_zero(oz4), .acc_count(ac4)
  );

  typedef struct {
    logic [2:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] c;
    logic [63:0] exp;
  } vec_t;

  localparam int N = 11;
  vec_t tbl [N];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic lane(input string tag, input int idx, input logic v,
                      input logic [63:0] d, input logic z);
    if (idx < 0 || idx == N) begin
      chk({tag, " idle valid"}, {63'd0, v}, 64'd0);
    end else if (idx < N) begin
      chk({tag, " valid"}, {63'd0, v}, 64'd1);
      chk({tag, " out"}, d, tbl[idx].exp);
      chk({tag, " zero"}, {63'd0, z}, {63'd0, tbl[idx].exp == 64'd0});
    end
  endtask

  task automatic drive(input logic [63:0] val);
    op  = 3'd5;
    in1 = val;
    in2 = 64'd0;
    in3 = 64'd0;
  endtask

  initial begin
    int acc;
    logic [63:0] nxt;

    tbl[0]  = '{3'd0, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00,
                64'h1, 64'h0F0F_0F0F_0F0F_0F0F};
    tbl[1]  = '{3'd1, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00,
                64'h1, 64'hF000_F000_F000_F000};
    tbl[2]  = '{3'd2, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00,
                64'h1, 64'h0FFF_0FFF_0FFF_0FFF};
    tbl[3]  = '{3'd3, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00,
                64'h1, 64'hFFF0_FFF0_FFF0_FFF0};
    tbl[4]  = '{3'd4, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00,
                64'h1, 64'h000F_000F_000F_000F};
    tbl[5]  = '{3'd5, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00,
                64'h1, 64'h0FF0_0FF0_0FF0_0FF0};
    tbl[6]  = '{3'd6, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00,
                64'h1, 64'hFF00_FF00_FF00_FF00};
    tbl[7]  = '{3'd7, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00,
                64'h1, 64'hF000_F000_F000_F000};
    tbl[8]  = '{3'd1, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555,
                64'h0, 64'h0};
    tbl[9]  = '{3'd6, 64'h1234_5678_9ABC_DEF0, 64'h0,
                64'hFFFF_FFFF_FFFF_FFFE, 64'h1234_5678_9ABC_DEF0};
    tbl[10] = '{3'd7, 64'hFF00_FF00_FF00_FF00, 64'h0F0F_0F0F_0F0F_0F0F,
                64'h3333_3333_3333_3333, 64'h3F03_3F03_3F03_3F03};

    rst       = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    drive(64'h5);
    tick();
    chk("reset rdy", {63'd0, rdy2}, 64'd0);
    chk("reset valid", {63'd0, ov2}, 64'd0);
    chk("reset out", od2, 64'd0);
    chk("reset zero", {63'd0, oz2}, 64'd1);
    chk("reset acc", {32'd0, ac2}, 64'd0);
    tick();
    chk("reset acc hold", {32'd0, ac2}, 64'd0);

    rst = 1'b0;
    for (int c = 0; c < N + 5; c++) begin
      if (c < N) begin
        in_valid = 1'b1;
        op  = tbl[c].op;
        in1 = tbl[c].a;
        in2 = tbl[c].b;
        in3 = tbl[c].c;
        #1;
        chk("s2 rdy", {63'd0, rdy2}, 64'd1);
        chk("s1 rdy", {63'd0, rdy1}, 64'd1);
        chk("s4 rdy", {63'd0, rdy4}, 64'd1);
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (c < N) chk("s2 acc", {32'd0, ac2}, 64'(c + 1));
      lane("s1", c, ov1, od1, oz1);
      lane("s2", c - 1, ov2, od2, oz2);
      lane("s4", c - 3, ov4, od4, oz4);
    end
    chk("s1 acc end", {32'd0, ac1}, 64'(N));
    chk("s4 acc end", {32'd0, ac4}, 64'(N));

    // Backpressure: only two operations fit.
    rst = 1'b1;
    tick();
    rst       = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      drive(64'(acc + 1));
      #1;
      if (c < 2) chk("bp rdy", {63'd0, rdy2}, 64'd1);
      else       chk("bp stall", {63'd0, rdy2}, 64'd0);
      if (rdy2) acc++;
      tick();
      if (c >= 1) begin
        chk("bp valid", {63'd0, ov2}, 64'd1);
        chk("bp hold", od2, 64'd1);
      end
    end
    chk("bp accepts", 64'(acc), 64'd2);
    chk("bp acc", {32'd0, ac2}, 64'd2);

    // Full pipeline: pop and push on the same edge.
    drive(64'd3);
    out_ready = 1'b1;
    #1;
    chk("fp rdy", {63'd0, rdy2}, 64'd1);
    tick();
    out_ready = 1'b0;
    chk("fp acc", {32'd0, ac2}, 64'd3);
    chk("fp out", od2, 64'd2);
    chk("fp valid", {63'd0, ov2}, 64'd1);
    drive(64'd4);
    #1;
    chk("fp full", {63'd0, rdy2}, 64'd0);
    tick();
    chk("fp hold", od2, 64'd2);

    // Drain in order.
    in_valid  = 1'b0;
    out_ready = 1'b1;
    nxt = 64'd2;
    for (int c = 0; c < 3; c++) begin
      if (nxt <= 64'd3) begin
        chk("drain valid", {63'd0, ov2}, 64'd1);
        chk("drain out", od2, nxt);
      end else begin
        chk("drain empty", {63'd0, ov2}, 64'd0);
      end
      nxt++;
      tick();
    end
    chk("drain acc", {32'd0, ac2}, 64'd3);

    // Reset with two results in flight.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(64'h77);
    tick();
    drive(64'h78);
    tick();
    chk("mf valid", {63'd0, ov2}, 64'd1);
    rst = 1'b1;
    #1;
    chk("mf rst rdy", {63'd0, rdy2}, 64'd0);
    tick();
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("mf valid", {63'd0, ov2}, 64'd0);
    chk("mf acc", {32'd0, ac2}, 64'd0);
    chk("mf out", od2, 64'd0);
    chk("mf zero", {63'd0, oz2}, 64'd1);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("mf stale", {63'd0, ov2}, 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
